vppm_demod: RTL and testbench



---
 rtl/vppm_pkg.sv | 34 +++
 rtl/sync_edge.sv | 39 +++
 rtl/vppm_demod.sv | 180 ++++++++++++++++++
 tb/tb_vppm_demod.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vppm_pkg.sv
// rtl/vppm_pkg.sv - shared VPPM types, error codes and timing defaults
// Purpose: state encoding, error cause codes, counter width and the nominal
//          symbol timing shared by the VPPM transmit and receive blocks.
// Ports:   none (package).
package vppm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_PERIOD   = 2'd1;
  localparam logic [1:0] ERR_STUCK_HI = 2'd2;
  localparam logic [1:0] ERR_STUCK_LO = 2'd3;

  localparam int CNT_W = 26;

  localparam int PERIOD_DEF  = 5000;
  localparam int TOL_DEF     = 250;
  localparam int TIMEOUT_DEF = 10000;

  // True when |p - nominal| <= tol; done in 64-bit signed so a short
  // measured period cannot wrap into a large positive difference.
  function automatic logic period_in_range(input logic [CNT_W-1:0] p,
                                           input int nominal,
                                           input int tol);
    longint diff;
    diff = longint'(p) - longint'(nominal);
    return (diff <= longint'(tol)) && (diff >= -longint'(tol));
  endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - 2-FF synchroniser with rise/fall edge detect
// Purpose: brings an asynchronous level into the clk domain and flags its
//          edges for one cycle each.
// Ports:   clk   in  system clock
//          rst   in  synchronous active-high reset
//          din   in  asynchronous input
//          level out synchronised level
//          rise  out one-cycle strobe on a 0->1 transition of level
//          fall  out one-cycle strobe on a 1->0 transition of level
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= din;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign level = r_sync;
  assign rise  = r_sync & ~r_prev;
  assign fall  = ~r_sync & r_prev;

endmodule

// File: rtl/vppm_demod.sv
// rtl/vppm_demod.sv - VPPM receive demodulator and word deserialiser
// Purpose: measures the period and high-time of each VPPM symbol, decides
//          the bit by comparing high-time to half the period, checks the
//          period against tolerance, detects a stuck line and packs bits
//          MSB-first into WORD_W-bit words.
// Ports:   clk_50     in  system clock
//          clear      in  synchronous active-high reset
//          din        in  asynchronous VPPM input
//          bit_out    out decided bit, valid with bit_valid
//          bit_valid  out one-cycle strobe per accepted symbol
//          width      out last latched high-time in cycles
//          period     out last latched period in cycles
//          data_out   out assembled word, valid with word_valid
//          word_valid out one-cycle strobe per completed word
//          err        out one-cycle error strobe
//          err_code   out cause of the last error (held)
//          locked     out high while tracking symbols (HIGH/LOW)
module vppm_demod
  import vppm_pkg::*;
#(
  parameter int PERIOD  = PERIOD_DEF,
  parameter int TOL     = TOL_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int WORD_W  = 8
) (
  input  logic              clk_50,
  input  logic              clear,
  input  logic              din,
  output logic              bit_out,
  output logic              bit_valid,
  output logic [CNT_W-1:0]  width,
  output logic [CNT_W-1:0]  period,
  output logic [WORD_W-1:0] data_out,
  output logic              word_valid,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              locked
);

  localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [BC_W-1:0]  LAST_BIT  = BC_W'(WORD_W - 1);

  logic w_level;
  logic w_rise;
  logic w_fall;

  sync_edge u_sync_edge (
    .clk   (clk_50),
    .rst   (clear),
    .din   (din),
    .level (w_level),
    .rise  (w_rise),
    .fall  (w_fall)
  );

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_width;
  logic [CNT_W-1:0]  r_period;
  logic              r_eval;
  logic [WORD_W-1:0] r_shift;
  logic [BC_W-1:0]   r_bitcnt;
  logic              r_bit_out;
  logic              r_bit_valid;
  logic [WORD_W-1:0] r_data_out;
  logic              r_word_valid;
  logic              r_err;
  logic [1:0]        r_err_code;
  logic              r_locked;

  // 2*width vs period in 27 bits so a long high-time cannot overflow.
  logic [CNT_W:0]    w_two_width;
  logic [CNT_W:0]    w_period_x;
  logic              w_bit;
  logic              w_period_ok;
  logic [WORD_W-1:0] w_shift_next;

  assign w_two_width  = {r_width, 1'b0};
  assign w_period_x   = {1'b0, r_period};
  assign w_bit        = (w_two_width > w_period_x);
  assign w_period_ok  = period_in_range(r_period, PERIOD, TOL);
  assign w_shift_next = {r_shift[WORD_W-2:0], w_bit};

  always_ff @(posedge clk_50) begin
    if (clear) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_width      <= '0;
      r_period     <= '0;
      r_eval       <= 1'b0;
      r_shift      <= '0;
      r_bitcnt     <= '0;
      r_bit_out    <= 1'b0;
      r_bit_valid  <= 1'b0;
      r_data_out   <= '0;
      r_word_valid <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_locked     <= 1'b0;
    end else begin
      r_bit_valid  <= 1'b0;
      r_word_valid <= 1'b0;
      r_err        <= 1'b0;
      r_eval       <= 1'b0;
      r_cnt        <= w_rise ? CNT_W'(1) : r_cnt + CNT_W'(1);

      // Edges are tested before the timeout so an edge landing on the
      // timeout cycle is still a valid symbol boundary.
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state  <= HIGH;
            r_locked <= 1'b1;
          end
        end
        HIGH: begin
          if (w_fall) begin
            r_width <= r_cnt;
            r_state <= LOW;
          end else if (r_cnt == TIMEOUT_C) begin
            r_err      <= 1'b1;
            r_err_code <= w_level ? ERR_STUCK_HI : ERR_STUCK_LO;
            r_bitcnt   <= '0;
            r_state    <= IDLE;
            r_locked   <= 1'b0;
          end
        end
        LOW: begin
          if (w_rise) begin
            r_period <= r_cnt;
            r_eval   <= 1'b1;
            r_state  <= HIGH;
          end else if (r_cnt == TIMEOUT_C) begin
            r_err      <= 1'b1;
            r_err_code <= w_level ? ERR_STUCK_HI : ERR_STUCK_LO;
            r_bitcnt   <= '0;
            r_state    <= IDLE;
            r_locked   <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_locked <= 1'b0;
        end
      endcase

      // Decision runs one cycle after the rise, once period is latched.
      // A timeout cannot coincide: cnt was just reloaded to 1.
      if (r_eval) begin
        if (!w_period_ok) begin
          r_err      <= 1'b1;
          r_err_code <= ERR_PERIOD;
        end else begin
          r_bit_out   <= w_bit;
          r_bit_valid <= 1'b1;
          r_shift     <= w_shift_next;
          if (r_bitcnt == LAST_BIT) begin
            r_data_out   <= w_shift_next;
            r_word_valid <= 1'b1;
            r_bitcnt     <= '0;
          end else begin
            r_bitcnt <= r_bitcnt + BC_W'(1);
          end
        end
      end
    end
  end

  assign bit_out    = r_bit_out;
  assign bit_valid  = r_bit_valid;
  assign width      = r_width;
  assign period     = r_period;
  assign data_out   = r_data_out;
  assign word_valid = r_word_valid;
  assign err        = r_err;
  assign err_code   = r_err_code;
  assign locked     = r_locked;

endmodule

// File: tb/tb_vppm_demod.sv
// tb/tb_vppm_demod.sv - scoreboard bench for vppm_demod
module tb_vppm_demod;

  localparam int PER = 500;
  localparam int TOL = 25;
  localparam int TMO = 1000;
  localparam int WW  = 8;

  logic        clk_50 = 1'b0;
  logic        clear  = 1'b1;
  logic        din    = 1'b0;
  logic        bit_out;
  logic        bit_valid;
  logic [25:0] width;
  logic [25:0] period;
  logic [7:0]  data_out;
  logic        word_valid;
  logic        err;
  logic [1:0]  err_code;
  logic        locked;

  always #10 clk_50 = ~clk_50;

  vppm_demod #(.PERIOD(PER), .TOL(TOL), .TIMEOUT(TMO), .WORD_W(WW)) dut (
    .clk_50     (clk_50),
    .clear      (clear),
    .din        (din),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .width      (width),
    .period     (period),
    .data_out   (data_out),
    .word_valid (word_valid),
    .err        (err),
    .err_code   (err_code),
    .locked     (locked)
  );

  typedef struct {
    bit         is_err;
    logic       b;
    int         w;
    int         p;
    logic [1:0] code;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] word_q[$];
  exp_t       mon_e;
  logic [7:0] mon_w;
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] m_shift  = '0;
  int         m_cnt    = 0;

  // Scoreboard: every bit/err strobe pops one expectation, every word
  // strobe pops one expected word.
  always @(negedge clk_50) begin
    if (!clear && (bit_valid || err)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event: bit_valid=%0b err=%0b err_code=%0d, required no event", bit_valid, err, err_code);
      end else begin
        mon_e = exp_q.pop_front();
        n_checks++;
        if ({bit_valid, err} !== (mon_e.is_err ? 2'b01 : 2'b10))
          $display("FAIL event_kind: {bit_valid,err}=%b, required %b", {bit_valid, err}, (mon_e.is_err ? 2'b01 : 2'b10));
        else n_pass++;
        if (!mon_e.is_err) begin
          n_checks++;
          if (bit_out !== mon_e.b) $display("FAIL bit_out: got %0b, required %0b", bit_out, mon_e.b);
          else n_pass++;
          n_checks++;
          if (width !== 26'(mon_e.w)) $display("FAIL width: got %0d, required %0d", width, mon_e.w);
          else n_pass++;
          n_checks++;
          if (period !== 26'(mon_e.p)) $display("FAIL period: got %0d, required %0d", period, mon_e.p);
          else n_pass++;
        end else begin
          n_checks++;
          if (err_code !== mon_e.code) $display("FAIL err_code: got %0d, required %0d", err_code, mon_e.code);
          else n_pass++;
          n_checks++;
          if (locked !== (mon_e.code == 2'd1)) $display("FAIL locked_at_err: got %0b, required %0b", locked, (mon_e.code == 2'd1));
          else n_pass++;
          if (mon_e.code == 2'd1) begin
            n_checks++;
            if (period !== 26'(mon_e.p)) $display("FAIL err_period: got %0d, required %0d", period, mon_e.p);
            else n_pass++;
          end
        end
      end
    end
    if (!clear && word_valid) begin
      n_checks++;
      if (word_q.size() == 0) begin
        $display("FAIL unexpected_word: data_out=%h, required no word", data_out);
      end else begin
        mon_w = word_q.pop_front();
        if (data_out !== mon_w) $display("FAIL data_out: got %h, required %h", data_out, mon_w);
        else n_pass++;
      end
      n_checks++;
      if (bit_valid !== 1'b1) $display("FAIL word_with_bit: bit_valid=%0b, required 1", bit_valid);
      else n_pass++;
    end
  end

  // One symbol: rise, 'high' cycles high, then low until 'per' cycles.
  task automatic sym(input int high, input int per);
    exp_t e;
    int   dev;
    dev = per - PER;
    if (dev < 0) dev = -dev;
    e.w = high;
    e.p = per;
    if (dev > TOL) begin
      e.is_err = 1'b1;
      e.b      = 1'b0;
      e.code   = 2'd1;
    end else begin
      e.is_err = 1'b0;
      e.b      = (2 * high > per);
      e.code   = 2'd0;
      m_shift  = {m_shift[6:0], e.b};
      m_cnt++;
      if (m_cnt == WW) begin
        word_q.push_back(m_shift);
        m_cnt = 0;
      end
    end
    exp_q.push_back(e);
    din = 1'b1;
    repeat (high) @(negedge clk_50);
    din = 1'b0;
    repeat (per - high) @(negedge clk_50);
  endtask

  task automatic sym_bit(input logic b);
    sym(b ? 340 : 160, PER);
  endtask

  task automatic push_stuck(input logic [1:0] c);
    exp_t e;
    e.is_err = 1'b1;
    e.b      = 1'b0;
    e.w      = 0;
    e.p      = 0;
    e.code   = c;
    exp_q.push_back(e);
    m_cnt = 0;
  endtask

  task automatic tail();
    din = 1'b1;
    repeat (20) @(negedge clk_50);
  endtask

  task automatic do_clear();
    din   = 1'b0;
    clear = 1'b1;
    repeat (5) @(negedge clk_50);
    clear   = 1'b0;
    m_shift = '0;
    m_cnt   = 0;
    repeat (5) @(negedge clk_50);
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL %s_events_pending: %0d left, required 0", name, exp_q.size());
      exp_q.delete();
    end else n_pass++;
    n_checks++;
    if (word_q.size() != 0) begin
      $display("FAIL %s_words_pending: %0d left, required 0", name, word_q.size());
      word_q.delete();
    end else n_pass++;
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({bit_out, bit_valid, width, period, data_out, word_valid, err, err_code, locked} !== '0)
      $display("FAIL %s_outputs_zero: bo=%0b bv=%0b w=%0d p=%0d d=%h wv=%0b e=%0b ec=%0d lk=%0b, required all 0",
               name, bit_out, bit_valid, width, period, data_out, word_valid, err, err_code, locked);
    else n_pass++;
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    n_checks++;
    if (got !== req) $display("FAIL %s: got %0b, required %0b", name, got, req);
    else n_pass++;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    din   = 1'b0;
    repeat (5) @(negedge clk_50);
    check_all_zero("reset");
    clear = 1'b0;
    repeat (5) @(negedge clk_50);
    check_bit("idle_unlocked", locked, 1'b0);
  endtask

  task automatic test_nominal();
    do_clear();
    for (int i = 0; i < 10; i++) sym(1598 / 10, PER);
    tail();
    check_bit("nominal_locked", locked, 1'b1);
    check_drained("nominal");
  endtask

  task automatic test_bit_one();
    do_clear();
    sym(340, PER);
    sym(340, PER);
    sym(250, PER);
    sym(251, PER);
    tail();
    check_drained("bit_one");
  endtask

  task automatic test_word();
    logic [7:0] pat;
    pat = 8'hB2;
    do_clear();
    for (int i = 7; i >= 0; i--) sym_bit(pat[i]);
    tail();
    check_drained("word");
    n_checks++;
    if (data_out !== 8'hB2) $display("FAIL word_hold: data_out=%h, required b2", data_out);
    else n_pass++;
  endtask

  task automatic test_period_err();
    do_clear();
    sym(160, 500);
    sym(160, 530);
    sym(340, 500);
    sym(160, 525);
    sym(160, 475);
    sym(160, 526);
    sym(340, 474);
    sym(340, 500);
    tail();
    check_bit("period_err_locked", locked, 1'b1);
    n_checks++;
    if (err_code !== 2'd1) $display("FAIL period_err_code_hold: got %0d, required 1", err_code);
    else n_pass++;
    check_drained("period_err");
  endtask

  task automatic test_timeout_edge();
    do_clear();
    sym(160, PER);
    sym(160, TMO);
    sym(340, PER);
    tail();
    check_bit("timeout_edge_locked", locked, 1'b1);
    check_drained("timeout_edge");
  endtask

  task automatic test_stuck_low();
    logic [7:0] pat;
    pat = 8'h5A;
    do_clear();
    sym_bit(1'b1);
    sym_bit(1'b1);
    sym_bit(1'b1);
    push_stuck(2'd3);
    din = 1'b1;
    repeat (160) @(negedge clk_50);
    din = 1'b0;
    repeat (1100) @(negedge clk_50);
    check_bit("stuck_low_unlocked", locked, 1'b0);
    n_checks++;
    if (err_code !== 2'd3) $display("FAIL stuck_low_code: got %0d, required 3", err_code);
    else n_pass++;
    for (int i = 7; i >= 0; i--) sym_bit(pat[i]);
    tail();
    check_bit("relock", locked, 1'b1);
    check_drained("stuck_low");
  endtask

  task automatic test_stuck_high();
    do_clear();
    sym_bit(1'b0);
    sym_bit(1'b1);
    push_stuck(2'd2);
    din = 1'b1;
    repeat (1100) @(negedge clk_50);
    din = 1'b0;
    repeat (20) @(negedge clk_50);
    check_bit("stuck_high_unlocked", locked, 1'b0);
    n_checks++;
    if (err_code !== 2'd2) $display("FAIL stuck_high_code: got %0d, required 2", err_code);
    else n_pass++;
    check_drained("stuck_high");
  endtask

  task automatic test_reset_midword();
    logic [7:0] pat;
    pat = 8'h3C;
    do_clear();
    sym_bit(1'b1);
    sym_bit(1'b1);
    sym_bit(1'b0);
    sym_bit(1'b1);
    sym_bit(1'b0);
    tail();
    repeat (30) @(negedge clk_50);
    check_drained("pre_midword");
    clear = 1'b1;
    din   = 1'b0;
    repeat (3) @(negedge clk_50);
    check_all_zero("midword");
    clear   = 1'b0;
    m_shift = '0;
    m_cnt   = 0;
    repeat (5) @(negedge clk_50);
    for (int i = 7; i >= 0; i--) sym_bit(pat[i]);
    tail();
    check_drained("post_midword");
    n_checks++;
    if (data_out !== 8'h3C) $display("FAIL midword_word: data_out=%h, required 3c", data_out);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bit_one();
    test_word();
    test_period_err();
    test_timeout_edge();
    test_stuck_low();
    test_stuck_high();
    test_reset_midword();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
